// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: the glyph table used by both the display
// encoder and this capture path, the idle anode pattern, and the capture FSM
// state type.
package seg7_pkg;

   // Active-low segment glyphs {g,f,e,d,c,b,a}, indexed by the nibble they show.
   // Index 15 is listed first because this is a packed array.
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'h0E,   // F
      7'h06,   // E
      7'h21,   // d
      7'h46,   // C
      7'h03,   // b
      7'h08,   // A
      7'h10,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

   // All anodes high: nothing is being driven onto the display.
   localparam logic [3:0] ANODE_BLANK = 4'b1111;

   // Capture FSM states.
   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_QUAL = 2'd1,
      ST_HELD = 2'd2
   } capture_state_t;

   // What a qualified dwell means, judged by its anode pattern.
   typedef enum logic [1:0] {
      AN_DIGIT   = 2'd0,
      AN_BLANK   = 2'd1,
      AN_ILLEGAL = 2'd2
   } anode_kind_t;

   // Classify an active-low anode pattern.
   function automatic anode_kind_t classify_anode(input logic [3:0] an_pat);
      case (an_pat)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: return AN_DIGIT;
         ANODE_BLANK:                        return AN_BLANK;
         default:                            return AN_ILLEGAL;
      endcase
   endfunction

   // Digit index selected by a one-hot-low anode pattern.
   function automatic logic [1:0] anode_index(input logic [3:0] an_pat);
      case (an_pat)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the seven-segment encoder: maps an active-low
// segment pattern back to the hex nibble it represents. Patterns that are
// not in the glyph table decode to nibble 0 with valid low.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0] glyph,
   output logic [3:0] nibble,
   output logic       valid
);

   // Search the shared glyph table; entries are unique so at most one hits.
   always_comb begin
      nibble = 4'h0;
      valid  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (glyph == GLYPH_TABLE[i]) begin
            nibble = 4'(i);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// Passive observer of a multiplexed four-digit seven-segment bus. Each anode
// dwell is qualified for stability, its glyph decoded back to a nibble and
// stored per digit. Frame completion, illegal anode patterns and a silent bus
// are reported alongside the captured value.
module seven_seg_scan_capture
   import seg7_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1048576
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [7:0]  sseg,
   output logic [15:0] digits,
   output logic [3:0]  dp,
   output logic [3:0]  digit_valid,
   output logic        frame_done,
   output logic        error,
   output logic        stale
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [11:0]    sync_meta;
   logic [11:0]    sync_word;
   logic [11:0]    prev_word;
   logic           word_changed;
   logic [3:0]     an_sync;
   logic [7:0]     seg_sync;

   capture_state_t state;
   capture_state_t state_next;
   logic [CNT_W-1:0] stable_cnt;
   logic [CNT_W-1:0] stable_cnt_next;
   logic           dwell_fire;

   anode_kind_t    an_kind;
   logic [1:0]     digit_idx;
   logic [3:0]     dec_nibble;
   logic           dec_valid;
   logic           capture_fire;
   logic           error_fire;

   logic [3:0]     seen;
   logic [3:0]     seen_set;
   logic [TMO_W-1:0] tmo_cnt;

   // Two-flop synchronizer; the all-ones reset value reads as an idle bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= '1;
         sync_word <= '1;
      end else begin
         sync_meta <= {an, sseg};
         sync_word <= sync_meta;
      end
   end

   // Remember last cycle's synchronized word so any change restarts qualification.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_word <= '1;
      end else begin
         prev_word <= sync_word;
      end
   end

   assign word_changed = (sync_word != prev_word);
   assign an_sync      = sync_word[11:8];
   assign seg_sync     = sync_word[7:0];

   seg7_glyph_decode u_decode (
      .glyph  (seg_sync[6:0]),
      .nibble (dec_nibble),
      .valid  (dec_valid)
   );

   // Dwell qualification state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_WAIT;
         stable_cnt <= '0;
      end else begin
         state      <= state_next;
         stable_cnt <= stable_cnt_next;
      end
   end

   // A change in any state starts a fresh count of 1 (the WAIT action); the
   // dwell fires once when the count reaches SETTLE_CYCLES, then HELD ignores
   // the word until it moves again.
   always_comb begin
      state_next      = state;
      stable_cnt_next = stable_cnt;
      dwell_fire      = 1'b0;
      if (word_changed) begin
         stable_cnt_next = CNT_W'(1);
         if (SETTLE_CYCLES <= 1) begin
            dwell_fire = 1'b1;
            state_next = ST_HELD;
         end else begin
            state_next = ST_QUAL;
         end
      end else begin
         case (state)
            ST_WAIT: begin
               state_next = ST_WAIT;
            end
            ST_QUAL: begin
               stable_cnt_next = stable_cnt + CNT_W'(1);
               if (stable_cnt_next == CNT_W'(SETTLE_CYCLES)) begin
                  dwell_fire = 1'b1;
                  state_next = ST_HELD;
               end
            end
            ST_HELD: begin
               state_next = ST_HELD;
            end
            default: begin
               state_next = ST_WAIT;
            end
         endcase
      end
   end

   assign an_kind      = classify_anode(an_sync);
   assign digit_idx    = anode_index(an_sync);
   assign capture_fire = dwell_fire && (an_kind == AN_DIGIT);
   assign error_fire   = dwell_fire && (an_kind == AN_ILLEGAL);
   assign seen_set     = seen | (4'b0001 << digit_idx);

   // Capture registers, frame tracking and the single-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits      <= '0;
         dp          <= '0;
         digit_valid <= '0;
         seen        <= '0;
         frame_done  <= 1'b0;
         error       <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         error      <= error_fire;
         if (capture_fire) begin
            digits[{digit_idx, 2'b00} +: 4] <= dec_nibble;
            dp[digit_idx]                   <= ~seg_sync[7];
            digit_valid[digit_idx]          <= dec_valid;
            if (seen_set == 4'b1111) begin
               frame_done <= 1'b1;
               seen       <= 4'b0000;
            end else begin
               seen       <= seen_set;
            end
         end
      end
   end

   // Cycles since the last capture, saturating at the timeout; a capture
   // always wins over saturation so stale drops on the capture edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (capture_fire) begin
         tmo_cnt <= '0;
      end else if (!stale) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   assign stale = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Self-checking bench for seven_seg_scan_capture. A behavioural model tracks
// how long the two-cycle-delayed bus word has been stable and applies the
// dwell rules directly; the DUT is compared against it every cycle, and a set
// of hand-computed expectations pins down the directed scenarios.
module tb_seven_seg_scan_capture;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  an = 4'hF;
   logic [7:0]  sseg = 8'hFF;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic [3:0]  digit_valid;
   logic        frame_done;
   logic        error;
   logic        stale;

   int n_checks = 0;
   int n_fail   = 0;
   int frames_seen = 0;
   int errors_seen = 0;

   logic [6:0] ref_glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seven_seg_scan_capture #(
      .SETTLE_CYCLES  (SETTLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .an          (an),
      .sseg        (sseg),
      .digits      (digits),
      .dp          (dp),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .error       (error),
      .stale       (stale)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [11:0] m_pin_d   = 12'hFFF;
   logic [11:0] m_word    = 12'hFFF;
   logic [11:0] m_new     = 12'hFFF;
   int          m_run     = SETTLE + 1;
   logic [15:0] m_digits  = '0;
   logic [3:0]  m_dp      = '0;
   logic [3:0]  m_valid   = '0;
   logic [3:0]  m_seen    = '0;
   logic        m_frame   = 1'b0;
   logic        m_err     = 1'b0;
   int          m_tmo     = 0;
   bit          m_cap;
   int          m_idx;
   int          m_zeros;
   logic [4:0]  m_dec;

   function automatic logic [4:0] ref_decode(input logic [6:0] g);
      logic [4:0] r;
      r = 5'b0_0000;
      for (int i = 0; i < 16; i++) begin
         if (g == ref_glyph[i]) r = {1'b1, 4'(i)};
      end
      return r;
   endfunction

   // The word seen by the observer lags the pins by two edges; a dwell acts
   // once, on the edge after its word has been stable for SETTLE cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pin_d  = 12'hFFF;
         m_word   = 12'hFFF;
         m_run    = SETTLE + 1;
         m_digits = '0;
         m_dp     = '0;
         m_valid  = '0;
         m_seen   = '0;
         m_frame  = 1'b0;
         m_err    = 1'b0;
         m_tmo    = 0;
      end else begin
         m_cap   = 1'b0;
         m_frame = 1'b0;
         m_err   = 1'b0;
         if (m_run == SETTLE) begin
            m_zeros = 4 - $countones(m_word[11:8]);
            if (m_zeros == 1) begin
               for (int i = 0; i < 4; i++) if (!m_word[8+i]) m_idx = i;
               m_dec = ref_decode(m_word[6:0]);
               m_digits[m_idx*4 +: 4] = m_dec[3:0];
               m_dp[m_idx]    = ~m_word[7];
               m_valid[m_idx] = m_dec[4];
               m_seen[m_idx]  = 1'b1;
               if (m_seen == 4'hF) begin
                  m_frame = 1'b1;
                  m_seen  = 4'h0;
               end
               m_cap = 1'b1;
            end else if (m_zeros > 1) begin
               m_err = 1'b1;
            end
         end
         if (m_cap) m_tmo = 0;
         else if (m_tmo < TIMEOUT) m_tmo = m_tmo + 1;
         m_new   = m_pin_d;
         m_pin_d = {an, sseg};
         if (m_new != m_word) begin
            m_word = m_new;
            m_run  = 1;
         end else if (m_run <= SETTLE) begin
            m_run = m_run + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare every output with the model once per cycle, away from the edge.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("model_digits", 32'(digits), 32'(m_digits));
         checkOutput("model_dp", 32'(dp), 32'(m_dp));
         checkOutput("model_valid", 32'(digit_valid), 32'(m_valid));
         checkOutput("model_frame", 32'(frame_done), 32'(m_frame));
         checkOutput("model_error", 32'(error), 32'(m_err));
         checkOutput("model_stale", 32'(stale), 32'(m_tmo == TIMEOUT));
      end
   end

   // Pulse counters used by the directed checks.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_done) frames_seen++;
         if (error) errors_seen++;
      end
   end

   task automatic applyStimulus(input logic [3:0] a, input logic [7:0] s, input int cycles);
      an   = a;
      sseg = s;
      repeat (cycles) @(negedge clk);
   endtask

   // Scan a 4-digit value, one 10-cycle dwell per digit; dp_mask bit i lights digit i's dp.
   task automatic scanValue(input logic [15:0] value, input logic [3:0] dp_mask);
      logic [3:0] nib;
      for (int d = 0; d < 4; d++) begin
         nib = value[d*4 +: 4];
         applyStimulus(~(4'b0001 << d), {~dp_mask[d], ref_glyph[nib]}, 10);
      end
   endtask

   int frames_before;
   int errors_before;
   int pick;
   logic [3:0] r_an;
   logic [7:0] r_seg;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset_digits", 32'(digits), 32'h0);
      checkOutput("reset_valid", 32'(digit_valid), 32'h0);
      checkOutput("reset_stale", 32'(stale), 32'h0);
      rst_n = 1'b1;

      // Single dwell: captured exactly on the sixth edge, then held
      an = 4'b1110; sseg = 8'hC0;
      repeat (5) @(negedge clk);
      checkOutput("dwell_before_capture", 32'(digit_valid), 32'h0);
      @(negedge clk);
      checkOutput("dwell_capture_valid", 32'(digit_valid), 32'h1);
      checkOutput("dwell_capture_digits", 32'(digits), 32'h0);
      checkOutput("dwell_capture_dp", 32'(dp), 32'h0);
      repeat (4) @(negedge clk);
      checkOutput("dwell_held_valid", 32'(digit_valid), 32'h1);

      // Full scans of A5F3 with dp on digit 2
      frames_before = frames_seen;
      scanValue(16'hA5F3, 4'b0100);
      checkOutput("scan_digits", 32'(digits), 32'hA5F3);
      checkOutput("scan_dp", 32'(dp), 32'h4);
      checkOutput("scan_valid", 32'(digit_valid), 32'hF);
      checkOutput("scan_frames", 32'(frames_seen - frames_before), 32'd1);
      scanValue(16'hA5F3, 4'b0100);
      checkOutput("rescan_frames", 32'(frames_seen - frames_before), 32'd2);

      // Illegal glyph, then illegal anode pattern
      applyStimulus(4'b1110, 8'hFF, 10);
      checkOutput("bad_glyph_digits", 32'(digits), 32'hA5F0);
      checkOutput("bad_glyph_valid", 32'(digit_valid), 32'hE);
      errors_before = errors_seen;
      applyStimulus(4'b1100, 8'hB0, 10);
      checkOutput("bad_anode_errors", 32'(errors_seen - errors_before), 32'd1);
      checkOutput("bad_anode_digits", 32'(digits), 32'hA5F0);

      // Glitch shorter than the settle window
      applyStimulus(4'b1101, 8'h99, 3);
      applyStimulus(4'b1110, 8'hC0, 10);
      checkOutput("glitch_digits", 32'(digits), 32'hA5F0);
      checkOutput("glitch_errors", 32'(errors_seen - errors_before), 32'd1);
      checkOutput("glitch_valid", 32'(digit_valid), 32'hF);

      // Timeout on an idle bus, cleared by the next capture
      rst_n = 1'b0; an = 4'hF; sseg = 8'hFF;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (31) @(negedge clk);
      checkOutput("stale_at_31", 32'(stale), 32'h0);
      @(negedge clk);
      checkOutput("stale_at_32", 32'(stale), 32'h1);
      an = 4'b1110; sseg = 8'hC0;
      repeat (5) @(negedge clk);
      checkOutput("stale_before_capture", 32'(stale), 32'h1);
      @(negedge clk);
      checkOutput("stale_cleared", 32'(stale), 32'h0);
      checkOutput("stale_capture_valid", 32'(digit_valid), 32'h1);
      repeat (4) @(negedge clk);

      // Reset in the middle of digit-2 qualification
      frames_before = frames_seen;
      applyStimulus(4'b1110, 8'hB0, 10);
      applyStimulus(4'b1101, 8'h8E, 10);
      applyStimulus(4'b1011, 8'h12, 4);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset_digits", 32'(digits), 32'h0);
      checkOutput("midreset_dp", 32'(dp), 32'h0);
      checkOutput("midreset_valid", 32'(digit_valid), 32'h0);
      checkOutput("midreset_pulses", 32'({frame_done, error, stale}), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(4'b1011, 8'h12, 10);
      applyStimulus(4'b0111, 8'h88, 10);
      checkOutput("midreset_no_frame", 32'(frames_seen - frames_before), 32'd0);
      checkOutput("midreset_partial", 32'(digits), 32'hA500);
      applyStimulus(4'b1110, 8'hB0, 10);
      applyStimulus(4'b1101, 8'h8E, 10);
      checkOutput("midreset_frame", 32'(frames_seen - frames_before), 32'd1);
      checkOutput("midreset_digits_final", 32'(digits), 32'hA5F3);

      // Randomized dwells checked against the model
      for (int n = 0; n < 120; n++) begin
         pick = $urandom_range(0, 9);
         if (pick < 6) r_an = ~(4'b0001 << $urandom_range(0, 3));
         else if (pick < 8) r_an = 4'hF;
         else r_an = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) < 7) r_seg = {1'($urandom_range(0, 1)), ref_glyph[$urandom_range(0, 15)]};
         else r_seg = 8'($urandom_range(0, 255));
         applyStimulus(r_an, r_seg, $urandom_range(1, 9));
      end
      applyStimulus(4'hF, 8'hFF, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_capture.md
# seven_seg_scan_capture

Passive observer of a time-multiplexed four-digit seven-segment bus (`an`/`sseg`, active-low) that reconstructs the displayed hex value. It qualifies each anode dwell, decodes the segment glyph back to a nibble, and stores it per digit. It is the decode-side counterpart of the display mux path. It serves as a loopback checker on the board (pins tapped back in) and as a self-check monitor in simulation.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive stable synchronized cycles required before a dwell is captured (≥1).
- `TIMEOUT_CYCLES`, default 1048576: cycles without a capture before `stale` asserts.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `an` in 4: anode enables, active-low; `an[i]` low selects digit i.
- `sseg` in 8: segments, active-low; `[0]`=a … `[6]`=g, `[7]`=dp.
- `digits` out 16: captured nibbles; digit i at `[4i+3:4i]`.
- `dp` out 4: captured decimal points, active-high (1 = lit).
- `digit_valid` out 4: bit i = last glyph captured for digit i was a legal hex glyph.
- `frame_done` out 1: one-cycle pulse when all four digits have been captured since the previous pulse.
- `error` out 1: one-cycle pulse when an illegal anode pattern (two or more low) qualifies.
- `stale` out 1: level; no capture for `TIMEOUT_CYCLES` cycles.

## Operation
- Inputs pass through a two-flop synchronizer. Flops reset to all-ones, which means the bus is idle.
- Stability tracking works on the synchronized 12-bit word {an, sseg}. Any change from the previous cycle restarts qualification.
- FSM states:
  - WAIT: word changed this cycle. Load the stable count with 1 and go to QUAL.
  - QUAL: word unchanged. Increment the count. On reaching `SETTLE_CYCLES`, perform the dwell action and go to HELD.
  - HELD: ignore until the word changes, then go to WAIT.
- Dwell action by anode pattern:
  - One-hot-low: capture `digits[i]`, `dp[i]`, `digit_valid[i]`, and set `seen[i]`.
  - 1111: no action (blank).
  - Any other pattern: pulse `error`. No capture.
- Glyph decode (`sseg[6:0]` hex → nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
  - Any other glyph: nibble 0, `digit_valid[i]`=0.
  - `dp` is ignored for decode.
- Frame tracking uses an internal `seen[3:0]`.
  - Recapturing a digit already seen leaves `seen` unchanged.
  - When a capture makes `seen`=1111, pulse `frame_done` in the same cycle the outputs update, and clear `seen` to 0000 (not to the current bit).
- Timeout counter: clears on every capture and saturates at `TIMEOUT_CYCLES`.
  - `stale`=1 while saturated.
  - `stale` clears on the cycle the next capture updates the outputs.
- Reset (asynchronous, any time, including mid-dwell):
  - `digits`=0, `dp`=0, `digit_valid`=0, `frame_done`=0, `error`=0, `stale`=0.
  - `seen`=0, timeout count=0, FSM=WAIT.
  - The first capture after reset requires a full fresh qualification.

## Timing
- Capture latency:
  - A pin change at edge N reaches the synchronized word at edge N+2.
  - Outputs update at edge N+2+`SETTLE_CYCLES`. Default: 6 cycles.
- Dwells shorter than `SETTLE_CYCLES` synchronized cycles are never captured and never flag `error`.
- Exactly one capture occurs per qualified dwell, however long it lasts.
- `frame_done` and `error` are registered single-cycle pulses. They are mutually exclusive because their dwells differ.
- Simultaneous timeout saturation and capture: the capture wins; `stale` stays 0.

## Structure
- Shared package `seg7_pkg` holds:
  - The 16 glyph constants (same table the encoder uses).
  - The blank/idle anode constant.
  - The FSM state enum.
- Sub-module `seg7_glyph_decode`: combinational `sseg[6:0]` → {valid, nibble}, built from the package constants.
- Synchronizer, FSM, timeout counter, and capture registers live in the top block.

## Test plan
- Reset, then drive an=1110, sseg=8'hC0 for 10 cycles → edge 6: `digits[3:0]`=0, `dp[0]`=0, `digit_valid[0]`=1. No further update during the dwell.
- Scan 0xA5F3 with dp lit on digit 2 (sseg[7]=0), 10 cycles per digit, an 1110→1101→1011→0111 → `digits`=16'hA5F3, `dp`=4'b0100, `digit_valid`=1111. One `frame_done` pulse on the digit-3 capture. Repeat the scan → exactly one more pulse.
- an=1110 with illegal glyph sseg=8'hFF → `digits[3:0]`=0, `digit_valid[0]`=0. an=1100 held 10 cycles → one `error` pulse, no `digits` change.
- Glitch: an=1101 for 3 synchronized cycles, then back to 1110 → no capture for digit 1 and no `error`.
- `TIMEOUT_CYCLES`=32, bus held at 1111 → `stale`=1 from cycle 32. Then one qualified dwell → `stale` returns to 0 on the capture edge.
- Assert `rst_n` low during the digit-2 QUAL of a scan → all outputs 0 immediately. After release, the interrupted scan produces no `frame_done` until all four digits are recaptured.
